// File: rtl/hazard_ctrl.sv
// Decode-stage pipeline sequencer: forwarding selects, load-use stalls, branch flushes, memory-wait freezes.
// Latency: all control outputs are combinational (zero cycles); state, shadow slots and counters update on posedge clk.
// Backpressure: mem_stall_req freezes everything and holds PC and IF/ID; a load-use hazard holds PC and IF/ID for one cycle.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset (all outputs forced to 0 while high)
//   id_*                     decoded fields of the instruction sitting in IF/ID
//   ex_br_taken              branch/jump in EX resolved taken this cycle
//   mem_stall_req            data memory busy
//   pc_hold, if_id_hold      hold the PC and IF/ID registers
//   if_id_flush              load a noop into IF/ID
//   id_ex_bubble             load a noop into ID/EX
//   fwd_a_sel, fwd_b_sel     operand source: 00 regfile, 01 EX, 10 MEM, 11 WB
//   ctrl_state               mode this cycle: 00 RUN, 01 LDSTALL, 10 FLUSH, 11 MEMWAIT
//   stall_cnt, flush_cnt     saturating event counters
module hazard_ctrl #(
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_W        = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [4:0]       id_rs1_idx,
   input  logic [4:0]       id_rs2_idx,
   input  logic             id_rs1_used,
   input  logic             id_rs2_used,
   input  logic [4:0]       id_rd_idx,
   input  logic             id_reg_wr,
   input  logic             id_rd_mem,
   input  logic             ex_br_taken,
   input  logic             mem_stall_req,
   output logic             pc_hold,
   output logic             if_id_hold,
   output logic             if_id_flush,
   output logic             id_ex_bubble,
   output logic [1:0]       fwd_a_sel,
   output logic [1:0]       fwd_b_sel,
   output logic [1:0]       ctrl_state,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   // Down-counter only needs to hold FLUSH_CYCLES-1.
   localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

   typedef enum logic [1:0] {
      ST_RUN     = 2'b00,
      ST_LDSTALL = 2'b01,
      ST_FLUSH   = 2'b10,
      ST_MEMWAIT = 2'b11
   } state_t;

   typedef struct packed {
      logic       vld;
      logic [4:0] rd;
      logic       reg_wr;
      logic       is_load;
   } slot_t;

   typedef struct packed {
      logic       haz;
      logic [1:0] sel;
   } fwd_t;

   // Registered state only ever holds RUN, FLUSH or MEMWAIT; LDSTALL lasts
   // exactly one cycle and is purely a combinational mode.
   state_t          state_q, state_d;
   state_t          saved_q, saved_d;
   state_t          base_state;
   state_t          mode;
   logic [FC_W-1:0] fcnt_q, fcnt_d;
   slot_t           ex_q, mem_q, wb_q, ex_d;
   logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

   fwd_t fwd_a, fwd_b;
   logic load_use;
   logic fwd_en;
   logic advance;
   logic br_accept;
   logic pc_hold_c, if_id_hold_c, if_id_flush_c, id_ex_bubble_c;

   function automatic logic slot_match(input slot_t s, input logic used, input logic [4:0] idx);
      return used && (idx != 5'd0) && s.vld && s.reg_wr && (s.rd == idx);
   endfunction

   // Youngest producer wins. A load still in EX cannot be forwarded; the
   // operand reads 00 and a hazard is flagged instead of falling back to an
   // older (stale) MEM/WB copy.
   function automatic fwd_t fwd_pick(input slot_t ex, input slot_t mem, input slot_t wb,
                                     input logic used, input logic [4:0] idx);
      fwd_t r;
      r = '0;
      if (slot_match(ex, used, idx)) begin
         if (ex.is_load) r.haz = 1'b1;
         else            r.sel = 2'b01;
      end else if (slot_match(mem, used, idx)) begin
         r.sel = 2'b10;
      end else if (slot_match(wb, used, idx)) begin
         r.sel = 2'b11;
      end
      return r;
   endfunction

   always_comb begin
      fwd_a    = fwd_pick(ex_q, mem_q, wb_q, id_rs1_used, id_rs1_idx);
      fwd_b    = fwd_pick(ex_q, mem_q, wb_q, id_rs2_used, id_rs2_idx);
      load_use = id_valid && (fwd_a.haz || fwd_b.haz);
   end

   // On the first cycle after a memory wait the interrupted state is live
   // again immediately, so the pending hazard/flush is re-evaluated that cycle.
   assign base_state = (state_q == ST_MEMWAIT) ? saved_q : state_q;

   always_comb begin
      state_d         = state_q;
      saved_d         = saved_q;
      fcnt_d          = fcnt_q;
      mode            = base_state;
      fwd_en          = 1'b0;
      advance         = 1'b0;
      br_accept       = 1'b0;
      pc_hold_c       = 1'b0;
      if_id_hold_c    = 1'b0;
      if_id_flush_c   = 1'b0;
      id_ex_bubble_c  = 1'b0;

      if (mem_stall_req) begin
         mode         = ST_MEMWAIT;
         pc_hold_c    = 1'b1;
         if_id_hold_c = 1'b1;
         state_d      = ST_MEMWAIT;
         saved_d      = base_state;
         fwd_en       = (base_state != ST_FLUSH);
      end else begin
         advance = 1'b1;
         if (ex_br_taken) begin
            // Branch beats any load-use hazard; the ID instruction is squashed.
            mode           = ST_FLUSH;
            br_accept      = 1'b1;
            if_id_flush_c  = 1'b1;
            id_ex_bubble_c = 1'b1;
            fcnt_d         = FC_W'(FLUSH_CYCLES - 1);
            state_d        = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
         end else if (base_state == ST_FLUSH) begin
            // ID holds a flushed noop: no forwarding, no hazard, nothing to EX.
            mode          = ST_FLUSH;
            if_id_flush_c = 1'b1;
            fcnt_d        = fcnt_q - FC_W'(1);
            state_d       = (fcnt_q <= FC_W'(1)) ? ST_RUN : ST_FLUSH;
         end else if (load_use) begin
            mode           = ST_LDSTALL;
            pc_hold_c      = 1'b1;
            if_id_hold_c   = 1'b1;
            id_ex_bubble_c = 1'b1;
            fwd_en         = 1'b1;
            state_d        = ST_RUN;
         end else begin
            mode    = ST_RUN;
            fwd_en  = 1'b1;
            state_d = ST_RUN;
         end
      end
   end

   always_comb begin
      ex_d = '0;
      if (id_valid && !id_ex_bubble_c && (mode != ST_FLUSH)) begin
         ex_d.vld     = 1'b1;
         ex_d.rd      = id_rd_idx;
         ex_d.reg_wr  = id_reg_wr;
         ex_d.is_load = id_rd_mem;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_RUN;
         saved_q <= ST_RUN;
         fcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         saved_q <= saved_d;
         fcnt_q  <= fcnt_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_q  <= '0;
         mem_q <= '0;
         wb_q  <= '0;
      end else if (advance) begin
         wb_q  <= mem_q;
         mem_q <= ex_q;
         ex_q  <= ex_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (pc_hold_c && (stall_cnt_q != {CNT_W{1'b1}}))
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         if (br_accept && (flush_cnt_q != {CNT_W{1'b1}}))
            flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
   end

   // Everything reads 0 while reset is held, independent of the inputs.
   always_comb begin
      pc_hold      = 1'b0;
      if_id_hold   = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b0;
      fwd_a_sel    = 2'b00;
      fwd_b_sel    = 2'b00;
      ctrl_state   = ST_RUN;
      if (!rst) begin
         pc_hold      = pc_hold_c;
         if_id_hold   = if_id_hold_c;
         if_id_flush  = if_id_flush_c;
         id_ex_bubble = id_ex_bubble_c;
         fwd_a_sel    = fwd_en ? fwd_a.sel : 2'b00;
         fwd_b_sel    = fwd_en ? fwd_b.sel : 2'b00;
         ctrl_state   = mode;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios then randomized traffic, all
// outputs compared every cycle against an in-flight instruction list model.
module tb_hazard_ctrl;

   localparam int FC    = 2;
   localparam int CW    = 4;
   localparam int CMAX  = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          id_valid = 1'b0;
   logic [4:0]    id_rs1_idx = '0;
   logic [4:0]    id_rs2_idx = '0;
   logic          id_rs1_used = 1'b0;
   logic          id_rs2_used = 1'b0;
   logic [4:0]    id_rd_idx = '0;
   logic          id_reg_wr = 1'b0;
   logic          id_rd_mem = 1'b0;
   logic          ex_br_taken = 1'b0;
   logic          mem_stall_req = 1'b0;
   logic          pc_hold, if_id_hold, if_id_flush, id_ex_bubble;
   logic [1:0]    fwd_a_sel, fwd_b_sel, ctrl_state;
   logic [CW-1:0] stall_cnt, flush_cnt;

   hazard_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst),
      .id_valid(id_valid), .id_rs1_idx(id_rs1_idx), .id_rs2_idx(id_rs2_idx),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
      .id_rd_idx(id_rd_idx), .id_reg_wr(id_reg_wr), .id_rd_mem(id_rd_mem),
      .ex_br_taken(ex_br_taken), .mem_stall_req(mem_stall_req),
      .pc_hold(pc_hold), .if_id_hold(if_id_hold), .if_id_flush(if_id_flush),
      .id_ex_bubble(id_ex_bubble), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
      .ctrl_state(ctrl_state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // pipe[0]=EX, pipe[1]=MEM, pipe[2]=WB : the instructions still in flight.
   typedef struct {
      bit v;
      int rd;
      bit wr;
      bit ld;
   } m_instr_t;

   m_instr_t pipe[3];
   int flush_rem;       // FLUSH cycles still owed after the branch cycle
   int m_stall, m_flush;

   // current cycle inputs and expected outputs
   bit c_v, c_u1, c_u2, c_wr, c_ld, c_br, c_req;
   int c_r1, c_r2, c_rd;
   bit e_pc, e_ifh, e_flush, e_bub;
   int e_fa, e_fb, e_st;

   task automatic model_reset();
      for (int k = 0; k < 3; k++) pipe[k] = '{0, 0, 0, 0};
      flush_rem = 0;
      m_stall   = 0;
      m_flush   = 0;
   endtask

   function automatic int op_src(input bit used, input int idx, output bit haz);
      haz = 0;
      if (!used || idx == 0) return 0;
      for (int k = 0; k < 3; k++) begin
         if (pipe[k].v && pipe[k].wr && pipe[k].rd == idx) begin
            if (k == 0 && pipe[k].ld) begin
               haz = 1;
               return 0;
            end
            return k + 1;
         end
      end
      return 0;
   endfunction

   task automatic model_eval();
      bit ha, hb, lu;
      int sa, sb;
      sa = op_src(c_u1, c_r1, ha);
      sb = op_src(c_u2, c_r2, hb);
      lu = c_v && (ha || hb);
      e_pc = 0; e_ifh = 0; e_flush = 0; e_bub = 0; e_fa = 0; e_fb = 0;
      if (c_req) begin
         e_st = 3; e_pc = 1; e_ifh = 1;
         if (flush_rem == 0) begin e_fa = sa; e_fb = sb; end
      end else if (c_br || flush_rem > 0) begin
         e_st = 2; e_flush = 1; e_bub = c_br;
      end else if (lu) begin
         e_st = 1; e_pc = 1; e_ifh = 1; e_bub = 1; e_fa = sa; e_fb = sb;
      end else begin
         e_st = 0; e_fa = sa; e_fb = sb;
      end
   endtask

   task automatic model_update();
      if (e_pc && m_stall < CMAX) m_stall++;
      if (!c_req) begin
         if (c_br) begin
            flush_rem = FC - 1;
            if (m_flush < CMAX) m_flush++;
         end else if (flush_rem > 0) begin
            flush_rem--;
         end
         pipe[2] = pipe[1];
         pipe[1] = pipe[0];
         pipe[0] = '{c_v && !e_bub && e_st != 2, c_rd, c_wr, c_ld};
      end
   endtask

   // Apply one cycle's inputs (called just after a negedge) and compare.
   task automatic drive(input bit v, input int r1, input int r2, input bit u1, input bit u2,
                        input int rd, input bit wr, input bit ld, input bit br, input bit req);
      c_v = v; c_r1 = r1; c_r2 = r2; c_u1 = u1; c_u2 = u2;
      c_rd = rd; c_wr = wr; c_ld = ld; c_br = br; c_req = req;
      id_valid = v; id_rs1_idx = 5'(r1); id_rs2_idx = 5'(r2);
      id_rs1_used = u1; id_rs2_used = u2; id_rd_idx = 5'(rd);
      id_reg_wr = wr; id_rd_mem = ld; ex_br_taken = br; mem_stall_req = req;
      #1;
      model_eval();
      check("pc_hold",      32'(pc_hold),      32'(e_pc));
      check("if_id_hold",   32'(if_id_hold),   32'(e_ifh));
      check("if_id_flush",  32'(if_id_flush),  32'(e_flush));
      check("id_ex_bubble", 32'(id_ex_bubble), 32'(e_bub));
      check("fwd_a_sel",    32'(fwd_a_sel),    32'(e_fa));
      check("fwd_b_sel",    32'(fwd_b_sel),    32'(e_fb));
      check("ctrl_state",   32'(ctrl_state),   32'(e_st));
      check("stall_cnt",    32'(stall_cnt),    32'(m_stall));
      check("flush_cnt",    32'(flush_cnt),    32'(m_flush));
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_pc_hold"},    32'(pc_hold),      0);
      check({tag, "_if_id_hold"}, 32'(if_id_hold),   0);
      check({tag, "_flush"},      32'(if_id_flush),  0);
      check({tag, "_bubble"},     32'(id_ex_bubble), 0);
      check({tag, "_fwd_a"},      32'(fwd_a_sel),    0);
      check({tag, "_fwd_b"},      32'(fwd_b_sel),    0);
      check({tag, "_state"},      32'(ctrl_state),   0);
      check({tag, "_stall_cnt"},  32'(stall_cnt),    0);
      check({tag, "_flush_cnt"},  32'(flush_cnt),    0);
   endtask

   initial begin
      model_reset();
      // Reset held with a hazard-looking, branching, stalling input pattern.
      id_valid = 1; id_rs1_used = 1; id_rs1_idx = 5'd3; ex_br_taken = 1; mem_stall_req = 1;
      repeat (2) @(negedge clk);
      check_all_zero("reset");
      rst = 0;

      // 1: ALU producer in EX forwards to rs1.
      drive(1, 0, 0, 0, 0, 5, 1, 0, 0, 0); tick();
      drive(1, 5, 1, 1, 1, 6, 1, 0, 0, 0);
      check("t1_fwd_a", 32'(fwd_a_sel), 1);
      check("t1_fwd_b", 32'(fwd_b_sel), 0);
      check("t1_no_stall", 32'(pc_hold), 0);
      tick();

      // 2: load-use stall then MEM forwarding.
      drive(1, 0, 0, 0, 0, 7, 1, 1, 0, 0); tick();
      drive(1, 7, 7, 1, 1, 8, 1, 0, 0, 0);
      check("t2_pc_hold", 32'(pc_hold), 1);
      check("t2_if_id_hold", 32'(if_id_hold), 1);
      check("t2_bubble", 32'(id_ex_bubble), 1);
      check("t2_state", 32'(ctrl_state), 1);
      tick();
      drive(1, 7, 7, 1, 1, 8, 1, 0, 0, 0);
      check("t2_fwd_a_mem", 32'(fwd_a_sel), 2);
      check("t2_fwd_b_mem", 32'(fwd_b_sel), 2);
      check("t2_stall_cnt", 32'(stall_cnt), 1);
      check("t2_released", 32'(pc_hold), 0);
      tick();

      // 3: x0 is never forwarded.
      drive(1, 0, 0, 0, 0, 0, 1, 1, 0, 0); tick();
      drive(1, 0, 0, 1, 1, 9, 1, 0, 0, 0);
      check("t3_fwd_a", 32'(fwd_a_sel), 0);
      check("t3_fwd_b", 32'(fwd_b_sel), 0);
      check("t3_no_stall", 32'(pc_hold), 0);
      tick();

      // 4: taken branch, two flush cycles, one bubble.
      drive(1, 9, 0, 1, 0, 10, 1, 0, 1, 0);
      check("t4_flush0", 32'(if_id_flush), 1);
      check("t4_bubble0", 32'(id_ex_bubble), 1);
      tick();
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      check("t4_flush1", 32'(if_id_flush), 1);
      check("t4_bubble1", 32'(id_ex_bubble), 0);
      check("t4_flush_cnt", 32'(flush_cnt), 1);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      check("t4_state_run", 32'(ctrl_state), 0);
      check("t4_flush2", 32'(if_id_flush), 0);
      tick();

      // 5: memory wait in the middle of FLUSH, branch during the wait ignored.
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); tick();
      for (int i = 0; i < 3; i++) begin
         drive(1, 1, 2, 1, 1, 3, 1, 0, 1, 1);
         check("t5_pc_hold", 32'(pc_hold), 1);
         check("t5_no_flush", 32'(if_id_flush), 0);
         tick();
      end
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      check("t5_resume_flush", 32'(if_id_flush), 1);
      check("t5_resume_state", 32'(ctrl_state), 2);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      check("t5_run", 32'(ctrl_state), 0);
      check("t5_flush_cnt", 32'(flush_cnt), 2);
      tick();

      // 6: asynchronous reset in the middle of a load-use stall.
      drive(1, 0, 0, 0, 0, 12, 1, 1, 0, 0); tick();
      drive(1, 12, 0, 1, 0, 13, 1, 0, 0, 0);
      check("t6_ldstall", 32'(ctrl_state), 1);
      #1 rst = 1;
      #1 check_all_zero("t6_async");
      @(negedge clk);
      rst = 0;
      model_reset();

      // Random traffic; small register set keeps dependencies frequent and the
      // 4-bit counters reach saturation.
      for (int n = 0; n < 600; n++) begin
         drive($urandom_range(0, 3) != 0,
               int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
               $urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0,
               int'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
               $urandom_range(0, 2) == 0,
               $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0);
         tick();
      end
      check("rand_stall_sat", 32'(stall_cnt), CMAX);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
